// File: rtl/bcd_counter_nd.sv
// Synchronous N-digit BCD counter with enable, up/down, sanitising parallel load,
// wrap or saturate at the boundary, and a combinational terminal count for cascading.
module bcd_counter_nd #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] count_q, count_d;
  logic         load_err_q, load_err_d;

  logic         all_nine, all_zero, at_bound;
  logic [W-1:0] load_clean;
  logic         load_bad;
  logic [W-1:0] count_step;
  logic         carry;
  logic [3:0]   ld_nib, cnt_nib;

  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (count_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (count_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
    end
    at_bound = up ? all_nine : all_zero;
  end

  // Any nibble above 9 loads as zero and flags the load as erroneous.
  always_comb begin
    load_bad   = 1'b0;
    load_clean = '0;
    ld_nib     = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      ld_nib = load_val[4*i +: 4];
      if (ld_nib > 4'd9) begin
        load_bad = 1'b1;
      end else begin
        load_clean[4*i +: 4] = ld_nib;
      end
    end
  end

  // Carry/borrow ripples from digit 0 upward within the cycle.
  always_comb begin
    count_step = count_q;
    carry      = 1'b1;
    cnt_nib    = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      cnt_nib = count_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (cnt_nib == 4'd9) begin
            count_step[4*i +: 4] = 4'd0;
          end else begin
            count_step[4*i +: 4] = cnt_nib + 4'd1;
            carry                = 1'b0;
          end
        end else begin
          if (cnt_nib == 4'd0) begin
            count_step[4*i +: 4] = 4'd9;
          end else begin
            count_step[4*i +: 4] = cnt_nib - 4'd1;
            carry                = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (load) begin
      count_d    = load_clean;
      load_err_d = load_bad;
    end else if (en) begin
      if (!(SATURATE && at_bound)) begin
        count_d = count_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign load_err = load_err_q;
  assign tc       = en & at_bound;

endmodule
